// File: rtl/tmr_ccp_pkg.sv
// tmr_ccp shared types: counting modes, control states, capture edge codes.
// Imported by the timer top and the capture edge sub-module.
package tmr_ccp_pkg;

    typedef enum logic [1:0] {
        CM_UP     = 2'd0,
        CM_DOWN   = 2'd1,
        CM_UPDOWN = 2'd2
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

endpackage

// File: rtl/tmr_ccp_if.sv
// tmr_ccp register-file side bundle: configuration in, counter/flags out.
// master = register file, slave = timer.
interface tmr_ccp_if #(
    parameter int W   = 32,
    parameter int PW  = 16,
    parameter int NCH = 4
);
    logic               en;
    logic [PW-1:0]      pre;
    logic [W-1:0]       top;
    logic [1:0]         cnt_mode;
    logic               one_shot;
    logic [NCH*W-1:0]   cmp;
    logic [NCH-1:0]     ch_cap;
    logic [2*NCH-1:0]   ch_edge;
    logic [NCH-1:0]     ch_pol;
    logic [NCH-1:0]     cap_in;
    logic               ovf_clr;
    logic [NCH-1:0]     ch_flag_clr;
    logic [NCH:0]       irq_mask;
    logic [W-1:0]       cnt;
    logic [NCH*W-1:0]   capture;
    logic [NCH-1:0]     pwm_out;
    logic               ovf;
    logic [NCH-1:0]     ch_flag;
    logic               irq;

    modport master (
        output en, pre, top, cnt_mode, one_shot, cmp, ch_cap, ch_edge,
        output ch_pol, cap_in, ovf_clr, ch_flag_clr, irq_mask,
        input  cnt, capture, pwm_out, ovf, ch_flag, irq
    );

    modport slave (
        input  en, pre, top, cnt_mode, one_shot, cmp, ch_cap, ch_edge,
        input  ch_pol, cap_in, ovf_clr, ch_flag_clr, irq_mask,
        output cnt, capture, pwm_out, ovf, ch_flag, irq
    );
endinterface

// File: rtl/tmr_ccp_edge.sv
// Capture pin synchroniser and edge detector with selectable edge.
// Emits a registered one-cycle pulse three edges after the pin is sampled.
module tmr_ccp_edge
    import tmr_ccp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pin,
    input  logic [1:0] i_sel,
    output logic       o_ev
);
    logic r_s1, r_s2, r_s3, r_ev;
    logic w_rise, w_fall, w_hit;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_hit  = (w_rise && (i_sel == EDGE_RISE || i_sel == EDGE_BOTH))
                 || (w_fall && (i_sel == EDGE_FALL || i_sel == EDGE_BOTH));

    // two-flop sync, one history flop, registered event pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_ev <= 1'b0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_ev <= w_hit;
        end
    end

    assign o_ev = r_ev;
endmodule

// File: rtl/tmr_ccp.sv
// Timer with shared up/down/centre counter and NCH compare/capture channels.
// Optional macro TMR_CCP_SHADOW_EN: top/cmp shadowed, reloaded in IDLE and at each UE.
module tmr_ccp
    import tmr_ccp_pkg::*;
#(
    parameter int W   = 32,
    parameter int PW  = 16,
    parameter int NCH = 4
) (
    input logic     clk,
    input logic     rst,
    tmr_ccp_if.slave bus
);
    state_e           r_state;
    logic [PW-1:0]    r_div;
    logic [W-1:0]     r_cnt;
    logic             r_dn;
    logic             r_ovf;
    logic             r_irq;
    logic [NCH-1:0]   r_flag;
    logic [NCH-1:0]   r_pwm;
    logic [NCH*W-1:0] r_cap;

    logic [W-1:0]     w_top;
    logic [NCH*W-1:0] w_cmp;
    logic [W-1:0]     w_start;
    logic [W-1:0]     w_cnt_nxt;
    logic [W-1:0]     w_one;
    logic             w_dn_nxt;
    logic             w_term;
    logic             w_run;
    logic             w_tick;
    logic             w_ue;
    logic             w_md_down;
    logic             w_md_ud;
    logic [NCH-1:0]   w_ev;
    logic [NCH-1:0]   w_set;

`ifdef TMR_CCP_SHADOW_EN
    logic [W-1:0]     r_top_a;
    logic [NCH*W-1:0] r_cmp_a;

    // active copies follow the inputs while idle and reload at each UE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top_a <= '0;
            r_cmp_a <= '0;
        end else if (r_state == ST_IDLE || w_ue) begin
            r_top_a <= bus.top;
            r_cmp_a <= bus.cmp;
        end
    end

    assign w_top = r_top_a;
    assign w_cmp = r_cmp_a;
`else
    assign w_top = bus.top;
    assign w_cmp = bus.cmp;
`endif

    assign w_one     = {{(W-1){1'b0}}, 1'b1};
    assign w_md_down = (bus.cnt_mode == CM_DOWN);
    assign w_md_ud   = (bus.cnt_mode == CM_UPDOWN);
    assign w_start   = w_md_down ? w_top : '0;
    assign w_run     = (r_state == ST_RUN);
    assign w_tick    = w_run && (r_div >= bus.pre);
    assign w_ue      = w_tick && w_term;

    // next count, direction and terminal detect for the selected mode
    always_comb begin
        w_term    = 1'b0;
        w_cnt_nxt = r_cnt;
        w_dn_nxt  = r_dn;
        if (w_md_ud) begin
            if (!r_dn) begin
                if (r_cnt >= w_top) begin
                    w_dn_nxt  = 1'b1;
                    w_cnt_nxt = (w_top == '0) ? '0 : r_cnt - w_one;
                end else begin
                    w_cnt_nxt = r_cnt + w_one;
                end
            end else if (r_cnt == '0) begin
                w_term    = 1'b1;
                w_dn_nxt  = 1'b0;
                w_cnt_nxt = (w_top == '0) ? '0 : w_one;
            end else begin
                w_cnt_nxt = r_cnt - w_one;
            end
        end else if (w_md_down) begin
            if (r_cnt == '0) begin
                w_term    = 1'b1;
                w_cnt_nxt = w_top;
            end else begin
                w_cnt_nxt = r_cnt - w_one;
            end
        end else begin
            if (r_cnt >= w_top) begin
                w_term    = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + w_one;
            end
        end
    end

    // control FSM with prescaler and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_dn    <= 1'b0;
        end else if (!bus.en) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= w_start;
            r_dn    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                    r_div   <= '0;
                    r_cnt   <= w_start;
                    r_dn    <= 1'b0;
                end
                ST_RUN: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_ue && bus.one_shot) begin
                        r_state <= ST_DONE;
                    end else if (w_tick) begin
                        r_cnt <= w_cnt_nxt;
                        r_dn  <= w_dn_nxt;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            tmr_ccp_edge u_edge (
                .clk   (clk),
                .rst   (rst),
                .i_pin (bus.cap_in[gi]),
                .i_sel (bus.ch_edge[2*gi +: 2]),
                .o_ev  (w_ev[gi])
            );
            assign w_set[gi] = bus.ch_cap[gi]
                ? (w_ev[gi] && w_run)
                : (w_tick && (r_cnt == w_cmp[gi*W +: W]));
        end
    endgenerate

    // sticky flags (set wins), irq, PWM outputs and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_flag <= '0;
            r_irq  <= 1'b0;
            r_pwm  <= '0;
            r_cap  <= '0;
        end else begin
            r_ovf  <= (r_ovf & ~bus.ovf_clr) | w_ue;
            r_flag <= (r_flag & ~bus.ch_flag_clr) | w_set;
            r_irq  <= |({r_ovf, r_flag} & bus.irq_mask);
            for (int i = 0; i < NCH; i++) begin
                r_pwm[i] <= !bus.ch_cap[i]
                         && ((r_cnt < w_cmp[i*W +: W]) ^ bus.ch_pol[i]);
                if (bus.ch_cap[i] && w_ev[i] && w_run)
                    r_cap[i*W +: W] <= r_cnt;
            end
        end
    end

    assign bus.cnt     = r_cnt;
    assign bus.capture = r_cap;
    assign bus.pwm_out = r_pwm;
    assign bus.ovf     = r_ovf;
    assign bus.ch_flag = r_flag;
    assign bus.irq     = r_irq;
endmodule
